// File: rtl/host_wb_writer.sv
`default_nettype none
// ============================================================================
// Module   : host_wb_writer
// Brief    : Wishbone classic single-write master fed by a valid/ready stream
//            of address/data pairs; latches bus errors/timeouts and drains a
//            failed load so the upstream assembler never stalls.
// Revision : 1.0 - initial release
// ============================================================================
module host_wb_writer #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [31:0] req_adr_i,
    input  logic [31:0] req_dat_i,
    input  logic        req_last_i,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    output logic [3:0]  wbm_sel_o,
    output logic        wbm_we_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic [2:0]  wbm_cti_o,
    output logic [1:0]  wbm_bte_o,
    input  logic        wbm_ack_i,
    input  logic        wbm_err_i,
    output logic        done_o,
    output logic        err_o,
    output logic [1:0]  err_code_o,
    input  logic        err_clr_i,
    output logic [15:0] wr_count_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUS   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    localparam logic [15:0] C_WAIT_LAST = 16'(TIMEOUT - 1);
    localparam logic [1:0]  C_CODE_ERR  = 2'b01;
    localparam logic [1:0]  C_CODE_TO   = 2'b10;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_adr;
    logic [31:0] r_dat;
    logic        r_last;
    logic [15:0] r_wait;
    logic        r_done;
    logic        r_err;
    logic [1:0]  r_code;
    logic [15:0] r_cnt;

    logic w_accept;
    logic w_clr;
    logic w_err_eff;
    logic w_bus_ack;
    logic w_bus_err;
    logic w_bus_to;
    logic w_bus_fail;

    assign req_ready_o = !rst_i && (r_state != ST_BUS);
    assign w_accept    = req_valid_i && req_ready_o;
    // A clear arriving with an accept must let that pair through.
    assign w_clr       = (r_state == ST_IDLE) && err_clr_i;
    assign w_err_eff   = r_err && !w_clr;
    assign w_bus_err   = (r_state == ST_BUS) && wbm_err_i;
    assign w_bus_ack   = (r_state == ST_BUS) && wbm_ack_i && !wbm_err_i;
    assign w_bus_to    = (r_state == ST_BUS) && !wbm_ack_i && !wbm_err_i
                         && (r_wait == C_WAIT_LAST);
    assign w_bus_fail  = w_bus_err || w_bus_to;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && !w_err_eff) begin
                    w_next = ST_BUS;
                end
            end
            ST_BUS: begin
                if (w_bus_ack) begin
                    w_next = ST_IDLE;
                end else if (w_bus_fail) begin
                    w_next = r_last ? ST_IDLE : ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (w_accept && req_last_i) begin
                    w_next = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_adr  <= '0;
            r_dat  <= '0;
            r_last <= 1'b0;
            r_wait <= '0;
            r_done <= 1'b0;
            r_err  <= 1'b0;
            r_code <= 2'b00;
            r_cnt  <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_clr) begin
                r_err  <= 1'b0;
                r_code <= 2'b00;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_accept && !w_err_eff) begin
                        r_adr  <= req_adr_i;
                        r_dat  <= req_dat_i;
                        r_last <= req_last_i;
                        r_wait <= '0;
                    end
                end
                ST_BUS: begin
                    r_wait <= r_wait + 16'd1;
                    if (w_bus_ack) begin
                        r_cnt  <= r_cnt + 16'd1;
                        r_done <= r_last;
                    end else if (w_bus_fail) begin
                        r_done <= r_last;
                        if (!r_err) begin
                            r_err  <= 1'b1;
                            r_code <= w_bus_err ? C_CODE_ERR : C_CODE_TO;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (w_accept && req_last_i) begin
                        r_done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign wbm_adr_o  = r_adr;
    assign wbm_dat_o  = r_dat;
    assign wbm_sel_o  = 4'hF;
    assign wbm_we_o   = 1'b1;
    assign wbm_cyc_o  = (r_state == ST_BUS);
    assign wbm_stb_o  = (r_state == ST_BUS);
    assign wbm_cti_o  = 3'b000;
    assign wbm_bte_o  = 2'b00;
    assign done_o     = r_done;
    assign err_o      = r_err;
    assign err_code_o = r_code;
    assign wr_count_o = r_cnt;

endmodule
`default_nettype wire
